divider: RTL
============

Name: divider

Overview:
- Iterative radix-2 restoring integer divider. It is the inverse-operation companion of the execution-stage multiplier.
- Sits in the execution stage beside the multiplier and serves DIV/REM-class instructions.
- Multi-cycle, one quotient bit per clock. Uses a start/busy/done handshake so the pipeline can stall on it.
- Results are held stable until the next accepted start.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.
- COUNT_WIDTH, 6, iteration counter width; must satisfy 2^COUNT_WIDTH > WIDTH.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  reset; one clock, reset is asynchronous and active-low.
- start_division  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured on an accepted start.
- divisor  input  WIDTH  denominator; captured on an accepted start.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when quotient/remainder become valid.
- division_by_zero  output  1  set with done when divisor was 0; held until next start.

Behaviour:
- Reset (async assert, sync release): state=IDLE; quotient, remainder, busy, done, division_by_zero = 0; counter = 0.
- States: IDLE, BUSY, FINISH.
- IDLE → BUSY: start_division=1 and divisor≠0. Latch operands, clear the partial remainder (WIDTH+1 bits), counter=0, busy=1.
- IDLE → FINISH: start_division=1 and divisor=0. Set quotient={WIDTH{1}}, remainder=dividend, division_by_zero=1.
- BUSY, each cycle:
  - shift {rem,quo} left 1, bringing in the dividend MSB;
  - trial = rem − divisor (WIDTH+1-bit);
  - if trial is non-negative: rem=trial and quotient LSB=1; else restore and LSB=0;
  - counter++.
  - After WIDTH iterations (counter==WIDTH−1 processed) → FINISH.
- FINISH: drive quotient/remainder, done=1 for exactly one cycle, busy=0 → IDLE.
- Latency:
  - normal: done is high in the cycle WIDTH+1 clocks after the accepted start edge (33 for WIDTH=32);
  - divide-by-zero: done one clock after start.
- busy goes high the cycle after the accepted start. busy and done are never high together.
- start_division while busy or in FINISH: ignored, with no queuing. Operand changes during BUSY have no effect.
- start in the same cycle done is high: ignored (FINISH is not IDLE).
- Outputs hold their last values in IDLE. A new accepted start clears division_by_zero.
- reset_n low mid-operation: immediate abort to IDLE, all outputs 0, no done pulse.
- Arithmetic is unsigned unless the optional feature is enabled. No overflow is possible unsigned.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit, captured on start).
  - When is_signed=1, operands are converted to magnitudes before iteration, and signs are corrected in FINISH.
  - The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - Divide-by-zero gives quotient = −1 and remainder = dividend.
  - Most-negative / −1 gives quotient = most-negative and remainder = 0, resolved in the cycle after start (latency 1), with no flag.
  - FINISH handles the correction, so total latency is unchanged.
- Undefined: the port is absent and behaviour is unsigned only.

Decomposition:
- Shared package divider_pkg:
  - state encoding constants DIV_IDLE=2'd0, DIV_BUSY=2'd1, DIV_FINISH=2'd2;
  - DIV_ZERO_QUOTIENT constant (all ones).
- One natural sub-module: divider_step, a combinational single-iteration shift/subtract/restore.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.

Test Plan:
- 100 / 7 unsigned → done at cycle 33 after start, quotient=14, remainder=2, division_by_zero=0; busy high cycles 1–32.
- 5 / 0 → done one cycle after start, quotient=0xFFFFFFFF, remainder=5, division_by_zero=1; next start 9/3 → flag cleared, quotient=3, remainder=0.
- 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0. Then 3 / 0xFFFFFFFF → quotient=0, remainder=3.
- Start 1000/10, then at cycle 5 pulse start with 8/2 → ignored; done once at cycle 33 with quotient=100, remainder=0.
- Start 77/5, drop reset_n at cycle 10 → outputs 0 asynchronously, no done; after release, 77/5 → quotient=15, remainder=2.
- With DIVIDER_SIGNED_EN, is_signed=1:
  - −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
  - 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, done one cycle after start.

Source files
------------

// File: rtl/divider_pkg.sv
// Purpose: shared state encoding and constants for the iterative restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BUSY   = 2'd1,
        DIV_FINISH = 2'd2
    } divState_t;

    // Widest operand the shared constants cover; users slice to WIDTH.
    localparam int DIV_MAX_WIDTH = 64;

    // Quotient reported for a zero divisor (all ones, i.e. -1 when signed).
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/divider_step.sv
// Purpose: one combinational radix-2 restoring iteration (shift, trial subtract, restore).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; evaluated every cycle, consumed only while the divider is busy.
//
// Ports:
//   rem     - partial remainder (WIDTH+1 bits)
//   quo     - dividend bits still to shift out / quotient bits shifted in so far
//   divisor - divisor magnitude
//   nextRem - partial remainder after this iteration
//   nextQuo - quo shifted left with the new quotient bit in the LSB
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   nextRem,
    output logic [WIDTH-1:0] nextQuo
);

    // One guard bit above the remainder so the borrow of the trial
    // subtraction lands in a dedicated sign bit.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
            nextRem = trial[WIDTH:0];
            nextQuo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            // Trial went negative: keep the shifted remainder unchanged.
            nextRem = shifted[WIDTH:0];
            nextQuo = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Purpose: iterative radix-2 restoring integer divider for DIV/REM-class instructions.
// Latency: WIDTH+1 clocks from accepted start to done; 1 clock for a zero divisor (and signed MIN/-1).
// Backpressure: start_division is only accepted in IDLE; starts while busy or done are dropped, not queued.
//
// Ports:
//   clock, reset_n            - rising-edge clock, asynchronous active-low reset
//   start_division            - request, sampled only while idle
//   dividend, divisor         - operands, captured on an accepted start
//   quotient, remainder       - results, held until the next accepted start completes
//   busy                      - high while an iteration sequence is in flight
//   done                      - one-cycle pulse when quotient/remainder become valid
//   division_by_zero          - set with done for a zero divisor, cleared by the next accepted start
//   is_signed                 - only with DIVIDER_SIGNED_EN defined: treat operands as two's complement
//
// Build option: define DIVIDER_SIGNED_EN to add is_signed and signed division; default is unsigned only.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 6     // must satisfy 2**COUNT_WIDTH > WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_division,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             division_by_zero
);

    divState_t              state;
    divState_t              nextState;
    logic [COUNT_WIDTH-1:0] counter;
    logic [WIDTH:0]         remReg;
    logic [WIDTH-1:0]       quoReg;
    logic [WIDTH-1:0]       divisorReg;

    logic [WIDTH:0]         stepRem;
    logic [WIDTH-1:0]       stepQuo;

    logic                   startAccept;
    logic                   divisorZero;
    logic                   lastIter;
    logic                   signedOverflow;
    logic [WIDTH-1:0]       opDividend;
    logic [WIDTH-1:0]       opDivisor;
    logic [WIDTH-1:0]       finalQuo;
    logic [WIDTH-1:0]       finalRem;

    assign startAccept = (state == DIV_IDLE) && start_division;
    assign divisorZero = (divisor == '0);
    assign lastIter    = (counter == COUNT_WIDTH'(WIDTH - 1));

`ifdef DIVIDER_SIGNED_EN
    logic dvdNeg;
    logic dvsNeg;
    logic negQuo;
    logic negRem;

    assign dvdNeg = is_signed & dividend[WIDTH-1];
    assign dvsNeg = is_signed & divisor[WIDTH-1];

    // The iteration always runs on magnitudes; MIN's magnitude is still
    // representable as an unsigned WIDTH-bit value.
    assign opDividend = dvdNeg ? -dividend : dividend;
    assign opDivisor  = dvsNeg ? -divisor  : divisor;

    // MIN / -1 is the only signed overflow; it bypasses the iteration.
    assign signedOverflow = is_signed
                          && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                          && (divisor == '1);

    // Sign correction is folded into the load of the result registers on
    // the final iteration so results are already corrected during FINISH.
    assign finalQuo = negQuo ? -stepQuo : stepQuo;
    assign finalRem = negRem ? -stepRem[WIDTH-1:0] : stepRem[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            negQuo <= 1'b0;
            negRem <= 1'b0;
        end else if (startAccept) begin
            negQuo <= dvdNeg ^ dvsNeg;
            negRem <= dvdNeg;
        end
    end
`else
    assign opDividend     = dividend;
    assign opDivisor      = divisor;
    assign signedOverflow = 1'b0;
    assign finalQuo       = stepQuo;
    assign finalRem       = stepRem[WIDTH-1:0];
`endif

    divider_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem     (remReg),
        .quo     (quoReg),
        .divisor (divisorReg),
        .nextRem (stepRem),
        .nextQuo (stepQuo)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= DIV_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. FINISH always returns to IDLE, so a start seen
    // while done is high is dropped.
    always_comb begin
        nextState = state;
        case (state)
            DIV_IDLE: begin
                if (start_division) begin
                    nextState = (divisorZero || signedOverflow) ? DIV_FINISH : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (lastIter) begin
                    nextState = DIV_FINISH;
                end
            end
            DIV_FINISH: nextState = DIV_IDLE;
            default:    nextState = DIV_IDLE;
        endcase
    end

    // Output decode; busy and done come from disjoint states.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            DIV_BUSY:   busy = 1'b1;
            DIV_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter          <= '0;
            remReg           <= '0;
            quoReg           <= '0;
            divisorReg       <= '0;
            quotient         <= '0;
            remainder        <= '0;
            division_by_zero <= 1'b0;
        end else if (startAccept) begin
            counter          <= '0;
            remReg           <= '0;
            quoReg           <= opDividend;
            divisorReg       <= opDivisor;
            division_by_zero <= divisorZero;
            if (divisorZero) begin
                quotient  <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                remainder <= dividend;
            end else if (signedOverflow) begin
                quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
                remainder <= '0;
            end
        end else if (state == DIV_BUSY) begin
            remReg  <= stepRem;
            quoReg  <= stepQuo;
            counter <= counter + 1'b1;
            if (lastIter) begin
                quotient  <= finalQuo;
                remainder <= finalRem;
            end
        end
    end

endmodule
